tile_plotter: RTL and testbench

// - Downstream drawing engine between bitmap/sprite scanners (e.g. banner, score and board renderers) and vga_adapter.
// - Accepts tile draw requests {tile column, tile row, colour} over a valid/ready handshake and buffers them in a 2-entry queue.
// - Expands each request into TILE_W x TILE_H single-pixel writes (x, y, colour, plot) at one pixel per clock.
// - Replaces per-scanner 2x2 counters so every screen renderer shares one scaled-pixel engine.

---
 rtl/tile_plotter_pkg.sv | 29 ++
 rtl/tile_plotter_req_fifo.sv | 66 ++++++
 rtl/tile_plotter.sv | 181 ++++++++++++++++++
 tb/tb_tile_plotter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_plotter_pkg.sv
// Shared definitions for the tile plotter: engine states, default geometry
// and the palette the screen renderers draw with.
package tile_plotter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DRAW = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int TILE_W_DEF   = 10;
   localparam int TILE_H_DEF   = 7;
   localparam int SCREEN_W_DEF = 160;
   localparam int SCREEN_H_DEF = 120;
   localparam int TX_W_DEF     = 4;
   localparam int TY_W_DEF     = 4;
   localparam int COLOUR_W_DEF = 3;

   localparam logic [2:0] BLACK   = 3'b000;
   localparam logic [2:0] BLUE    = 3'b001;
   localparam logic [2:0] GREEN   = 3'b010;
   localparam logic [2:0] CYAN    = 3'b011;
   localparam logic [2:0] RED     = 3'b100;
   localparam logic [2:0] MAGENTA = 3'b101;
   localparam logic [2:0] YELLOW  = 3'b110;
   localparam logic [2:0] WHITE   = 3'b111;

endpackage

// File: rtl/tile_plotter_req_fifo.sv
// Two-entry FIFO holding pending tile draw requests between the renderers
// and the pixel engine.
module tile_req_fifo
   import tile_plotter_pkg::*;
#(
   parameter int WIDTH = TX_W_DEF + TY_W_DEF + COLOUR_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == 2'd2);
   assign empty   = (count_q == 2'd0);
   assign dout    = mem_q[rd_ptr_q];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (do_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/tile_plotter.sv
// Shared scaled-pixel engine: expands queued tile requests into one pixel
// write per clock for vga_adapter, clipping anything off the visible screen.
module tile_plotter
   import tile_plotter_pkg::*;
#(
   parameter int TILE_W   = TILE_W_DEF,
   parameter int TILE_H   = TILE_H_DEF,
   parameter int SCREEN_W = SCREEN_W_DEF,
   parameter int SCREEN_H = SCREEN_H_DEF,
   parameter int TX_W     = TX_W_DEF,
   parameter int TY_W     = TY_W_DEF,
   parameter int COLOUR_W = COLOUR_W_DEF
) (
   input  logic                fastclock,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [TX_W-1:0]     req_tx,
   input  logic [TY_W-1:0]     req_ty,
   input  logic [COLOUR_W-1:0] req_colour,
   output logic [7:0]          x,
   output logic [6:0]          y,
   output logic [COLOUR_W-1:0] colour,
   output logic                plot,
   output logic                busy,
   output logic                tile_done
);

   localparam int FIFO_W = TX_W + TY_W + COLOUR_W;
   localparam int BX_W   = 9;
   localparam int BY_W   = 8;
   localparam int PX_W   = BX_W + 1;
   localparam int PY_W   = BY_W + 1;
   localparam int COL_W  = $clog2(TILE_W + 1);
   localparam int ROW_W  = $clog2(TILE_H + 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(TILE_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(TILE_H - 1);

   logic [FIFO_W-1:0]   fifo_dout;
   logic                fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [TX_W-1:0]     head_tx;
   logic [TY_W-1:0]     head_ty;
   logic [COLOUR_W-1:0] head_colour;

   state_t              state_q, state_d;
   logic [COL_W-1:0]    col_q, col_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [BX_W-1:0]     base_x_q, base_x_d;
   logic [BY_W-1:0]     base_y_q, base_y_d;
   logic [COLOUR_W-1:0] fill_q, fill_d;
   logic [7:0]          x_q, x_d;
   logic [6:0]          y_q, y_d;
   logic [COLOUR_W-1:0] colour_q, colour_d;
   logic                plot_q, plot_d;
   logic                tile_done_q, tile_done_d;

   logic                emit;
   logic [BX_W-1:0]     src_bx;
   logic [BY_W-1:0]     src_by;
   logic [COLOUR_W-1:0] src_colour;
   logic [PX_W-1:0]     px;
   logic [PY_W-1:0]     py;

   assign req_ready = !fifo_full;
   assign fifo_push = req_valid && req_ready;
   assign busy      = !fifo_empty || (state_q != IDLE);

   assign head_tx     = fifo_dout[FIFO_W-1 -: TX_W];
   assign head_ty     = fifo_dout[COLOUR_W +: TY_W];
   assign head_colour = fifo_dout[COLOUR_W-1:0];

   tile_req_fifo #(
      .WIDTH (FIFO_W)
   ) u_fifo (
      .clk   (fastclock),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   ({req_tx, req_ty, req_colour}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // LOAD already registers pixel (0,0) so the first plot appears in the
   // first DRAW cycle; each DRAW cycle registers the following pixel.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      base_x_d    = base_x_q;
      base_y_d    = base_y_q;
      fill_d      = fill_q;
      tile_done_d = 1'b0;
      fifo_pop    = 1'b0;
      emit        = 1'b0;
      src_bx      = base_x_q;
      src_by      = base_y_q;
      src_colour  = fill_q;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) state_d = LOAD;
         end
         LOAD: begin
            fifo_pop   = 1'b1;
            base_x_d   = BX_W'(head_tx) * BX_W'(TILE_W);
            base_y_d   = BY_W'(head_ty) * BY_W'(TILE_H);
            fill_d     = head_colour;
            col_d      = '0;
            row_d      = '0;
            src_bx     = base_x_d;
            src_by     = base_y_d;
            src_colour = head_colour;
            emit       = 1'b1;
            state_d    = DRAW;
         end
         DRAW: begin
            if (col_q == COL_LAST && row_q == ROW_LAST) begin
               state_d     = DONE;
               tile_done_d = 1'b1;
            end else begin
               if (col_q == COL_LAST) begin
                  col_d = '0;
                  row_d = row_q + ROW_W'(1);
               end else begin
                  col_d = col_q + COL_W'(1);
               end
               emit = 1'b1;
            end
         end
         DONE: begin
            state_d = fifo_empty ? IDLE : LOAD;
         end
         default: state_d = IDLE;
      endcase

      // Widened sums so off-screen coordinates are clipped, not wrapped.
      px       = PX_W'(src_bx) + PX_W'(col_d);
      py       = PY_W'(src_by) + PY_W'(row_d);
      x_d      = emit ? px[7:0] : x_q;
      y_d      = emit ? py[6:0] : y_q;
      colour_d = emit ? src_colour : colour_q;
      plot_d   = emit && (px < PX_W'(SCREEN_W)) && (py < PY_W'(SCREEN_H));
   end

   always_ff @(posedge fastclock) begin
      if (reset) begin
         state_q     <= IDLE;
         col_q       <= '0;
         row_q       <= '0;
         base_x_q    <= '0;
         base_y_q    <= '0;
         fill_q      <= '0;
         x_q         <= '0;
         y_q         <= '0;
         colour_q    <= '0;
         plot_q      <= 1'b0;
         tile_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         base_x_q    <= base_x_d;
         base_y_q    <= base_y_d;
         fill_q      <= fill_d;
         x_q         <= x_d;
         y_q         <= y_d;
         colour_q    <= colour_d;
         plot_q      <= plot_d;
         tile_done_q <= tile_done_d;
      end
   end

   assign x         = x_q;
   assign y         = y_q;
   assign colour    = colour_q;
   assign plot      = plot_q;
   assign tile_done = tile_done_q;

endmodule

// File: tb/tb_tile_plotter.sv
// Self-checking bench for tile_plotter: a schedule-level model of accepted
// tiles predicts every output cycle by cycle.
module tb_tile_plotter;

   localparam int TW   = 10;
   localparam int TH   = 7;
   localparam int NPIX = TW * TH;
   localparam int SW   = 160;
   localparam int SH   = 120;

   logic       fastclock  = 1'b0;
   logic       reset      = 1'b1;
   logic       req_valid  = 1'b0;
   logic [3:0] req_tx     = '0;
   logic [3:0] req_ty     = '0;
   logic [2:0] req_colour = '0;
   logic       req_ready;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       plot, busy, tile_done;

   logic       req_valid5 = 1'b0;
   logic [4:0] req_ty5    = '0;
   logic       req_ready5;
   logic [7:0] x5;
   logic [6:0] y5;
   logic [2:0] colour5;
   logic       plot5, busy5, tile_done5;

   int  vectors     = 0;
   int  miscompares = 0;
   int  cyc         = 0;
   int  plot_seen   = 0;
   int  done_seen   = 0;
   bit  accepted_now = 1'b0;
   bit  zero_hold    = 1'b1;

   // Model: every accepted tile with its accept cycle and first-pixel cycle.
   int tile_acc[$];
   int tile_start[$];
   int tile_tx[$];
   int tile_ty[$];
   int tile_col[$];

   always #10 fastclock = ~fastclock;

   tile_plotter dut (
      .fastclock  (fastclock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_tx     (req_tx),
      .req_ty     (req_ty),
      .req_colour (req_colour),
      .x          (x),
      .y          (y),
      .colour     (colour),
      .plot       (plot),
      .busy       (busy),
      .tile_done  (tile_done)
   );

   tile_plotter #(.TY_W(5)) dut5 (
      .fastclock  (fastclock),
      .reset      (reset),
      .req_valid  (req_valid5),
      .req_ready  (req_ready5),
      .req_tx     (req_tx),
      .req_ty     (req_ty5),
      .req_colour (req_colour),
      .x          (x5),
      .y          (y5),
      .colour     (colour5),
      .plot       (plot5),
      .busy       (busy5),
      .tile_done  (tile_done5)
   );

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   function automatic int model_count(input int n);
      int c = 0;
      foreach (tile_acc[i]) if (tile_acc[i] <= n && n < tile_start[i]) c++;
      return c;
   endfunction

   // One clock: update the schedule for this edge, then check every output.
   task automatic step();
      bit take;
      int st, k, ex, ey, ec, ep, edone, ebusy;
      bit drawing;
      take = req_valid && !reset && (model_count(cyc) < 2);
      @(posedge fastclock);
      cyc++;
      accepted_now = 1'b0;
      if (reset) begin
         tile_acc.delete(); tile_start.delete(); tile_tx.delete();
         tile_ty.delete(); tile_col.delete();
         zero_hold = 1'b1;
      end else if (take) begin
         st = cyc + 2;
         if (tile_start.size() > 0 && tile_start[$] + NPIX + 2 > st) st = tile_start[$] + NPIX + 2;
         tile_acc.push_back(cyc);
         tile_start.push_back(st);
         tile_tx.push_back(int'(req_tx));
         tile_ty.push_back(int'(req_ty));
         tile_col.push_back(int'(req_colour));
         accepted_now = 1'b1;
      end
      #1;
      drawing = 1'b0; ex = 0; ey = 0; ec = 0; ep = 0; edone = 0; ebusy = 0;
      foreach (tile_start[i]) begin
         k = cyc - tile_start[i];
         if (k >= 0 && k < NPIX) begin
            drawing = 1'b1;
            ex = tile_tx[i] * TW + k % TW;
            ey = tile_ty[i] * TH + k / TW;
            ec = tile_col[i];
            ep = (ex < SW && ey < SH) ? 1 : 0;
         end
         if (tile_start[i] + NPIX == cyc) edone = 1;
         if (tile_acc[i] <= cyc && cyc <= tile_start[i] + NPIX) ebusy = 1;
      end
      chk("plot", 32'(plot), ep);
      chk("tile_done", 32'(tile_done), edone);
      chk("busy", 32'(busy), ebusy);
      chk("req_ready", 32'(req_ready), (model_count(cyc) < 2) ? 1 : 0);
      if (drawing) begin
         chk("x", 32'(x), ex % 256);
         chk("y", 32'(y), ey % 128);
         chk("colour", 32'(colour), ec);
         zero_hold = 1'b0;
      end else if (zero_hold) begin
         chk("x_reset", 32'(x), 0);
         chk("y_reset", 32'(y), 0);
         chk("colour_reset", 32'(colour), 0);
      end
      if (plot === 1'b1) plot_seen++;
      if (tile_done === 1'b1) done_seen++;
   endtask

   // Present a request (valid left high) and wait, bounded, for acceptance.
   task automatic send(input int tx, input int ty, input int c);
      int g = 0;
      req_tx = 4'(tx); req_ty = 4'(ty); req_colour = 3'(c); req_valid = 1'b1;
      do begin
         step();
         g++;
      end while (!accepted_now && g < 400);
      chk("accept_bound", 32'(accepted_now), 1);
   endtask

   task automatic run5(input int ty, input int exp_plots);
      int a5, p5 = 0, d5 = 0, k;
      logic [2:0] c5;
      c5 = 3'($urandom_range(0, 7));
      req_tx = 4'd15; req_ty5 = 5'(ty); req_colour = c5; req_valid5 = 1'b1;
      step();
      a5 = cyc;
      req_valid5 = 1'b0;
      repeat (NPIX + 5) begin
         step();
         k = cyc - a5 - 2;
         if (k >= 0 && k < NPIX && plot5 === 1'b1) p5++;
         if (k == 0) begin
            chk("clip_first_x", 32'(x5), 150);
            chk("clip_first_y", 32'(y5), (ty * TH) % 128);
            chk("clip_first_colour", 32'(colour5), 32'(c5));
         end
         if (tile_done5 === 1'b1) begin
            d5++;
            chk("clip_done_time", k, NPIX);
         end
      end
      chk("clip_plots", p5, exp_plots);
      chk("clip_done_count", d5, 1);
      chk("clip_busy_end", 32'(busy5), 0);
      chk("clip_ready_end", 32'(req_ready5), 1);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int a0, a1, a2, sa, sb, g;

      // Reset, then idle.
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      repeat (10) step();

      // Single tile (2,3) yellow.
      plot_seen = 0; done_seen = 0;
      send(2, 3, 6);
      req_valid = 1'b0;
      step();
      chk("single_lat1_plot", 32'(plot), 0);
      step();
      chk("single_first_plot", 32'(plot), 1);
      chk("single_first_x", 32'(x), 20);
      chk("single_first_y", 32'(y), 21);
      repeat (73) step();
      chk("single_plots", plot_seen, 70);
      chk("single_dones", done_seen, 1);
      chk("single_busy_end", 32'(busy), 0);

      // Three requests held valid back-to-back.
      plot_seen = 0; done_seen = 0;
      send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
      a0 = cyc;
      send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
      a1 = cyc;
      send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
      a2 = cyc;
      req_valid = 1'b0;
      chk("b2b_second_accept", a1 - a0, 1);
      chk("b2b_third_accept", a2 - a0, 3);
      repeat (225) step();
      chk("b2b_plots", plot_seen, 210);
      chk("b2b_dones", done_seen, 3);

      // Bottom-right corner tile, fully visible.
      plot_seen = 0; done_seen = 0;
      send(15, 15, 7);
      req_valid = 1'b0;
      repeat (75) step();
      chk("corner_plots", plot_seen, 70);
      chk("corner_dones", done_seen, 1);

      // Vertical clipping on the wide-row build.
      run5(17, 10);
      run5(18, 0);

      // Random requests with random gaps.
      for (int i = 0; i < 8; i++) begin
         send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
         req_valid = 1'b0;
         repeat ($urandom_range(0, 80)) step();
      end
      repeat (250) step();
      chk("random_busy_end", 32'(busy), 0);

      // Push coinciding with the LOAD pop.
      plot_seen = 0; done_seen = 0;
      send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
      send($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7));
      req_valid = 1'b0;
      sb = tile_start[$];
      g = 0;
      while (cyc < sb - 1 && g < 500) begin
         step();
         g++;
      end
      req_tx = 4'($urandom_range(0, 15)); req_ty = 4'($urandom_range(0, 15));
      req_colour = 3'($urandom_range(0, 7)); req_valid = 1'b1;
      step();
      req_valid = 1'b0;
      chk("pushpop_accepted", 32'(accepted_now), 1);
      chk("pushpop_cycle", cyc, sb);
      chk("pushpop_ready", 32'(req_ready), 1);
      repeat (220) step();
      chk("pushpop_plots", plot_seen, 210);
      chk("pushpop_dones", done_seen, 3);

      // Reset at pixel 30 with one request queued.
      send(4, 5, 3);
      sa = tile_start[$];
      send(6, 7, 5);
      req_valid = 1'b0;
      g = 0;
      while (cyc < sa + 30 && g < 200) begin
         step();
         g++;
      end
      chk("reset_at_pixel30", cyc - sa, 30);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("reset_plot", 32'(plot), 0);
      chk("reset_busy", 32'(busy), 0);
      plot_seen = 0; done_seen = 0;
      repeat (200) step();
      chk("reset_plots_after", plot_seen, 0);
      chk("reset_dones_after", done_seen, 0);
      chk("reset_ready_after", 32'(req_ready), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
